rf_array_buffer_arb: RTL
========================

RF_ARRAY_BUFFER_ARB -- requirements
Module: rf_array_buffer_arb

Interface
REQ-001 Parameter NUM_CH, default 2, number of requesting channels (>=1).
REQ-002 Parameter ADDR_WIDTH, default 10, word address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter DATA_WIDTH, default 32, word width; SHALL be a multiple of 8.
REQ-004 Derived: CH_W = max(1, clog2(NUM_CH)); BE_W = DATA_WIDTH/8.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  NUM_CH  per-channel request valid.
REQ-008 req_ready  out  NUM_CH  per-channel grant/accept.
REQ-009 req_write  in  NUM_CH  1=write, 0=read.
REQ-010 req_addr  in  NUM_CH*ADDR_WIDTH  packed, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 req_wdata  in  NUM_CH*DATA_WIDTH  packed write data.
REQ-012 req_be  in  NUM_CH*BE_W  packed byte enables.
REQ-013 rsp_valid  out  1  read response valid.
REQ-014 rsp_ready  in  1  read response accept.
REQ-015 rsp_ch  out  CH_W  channel that issued the read.
REQ-016 rsp_data  out  DATA_WIDTH  read data.
REQ-017 init_done  out  1  array ready for traffic.

Function
REQ-018 Single-port storage array of DEPTH x DATA_WIDTH; at most one access per cycle.
REQ-019 Handshake completes on a channel when req_valid[i] && req_ready[i] at a rising edge; at most one req_ready bit high per cycle.
REQ-020 req_ready SHALL be combinational from req_valid, round-robin pointer, stall and init_done; it SHALL NOT assert for a channel with req_valid low.
REQ-021 Round-robin: search starts at pointer rr_ptr upward modulo NUM_CH; first valid channel wins; after grant g, rr_ptr <= (g+1) mod NUM_CH; no grant -> rr_ptr unchanged.
REQ-022 Write: byte k of word updated iff req_be bit k set; other bytes retained; writes generate no response.
REQ-023 Read: rsp_valid asserts exactly 1 cycle after the handshake, with rsp_ch = granting channel, rsp_data = array word at that edge.
REQ-024 Stall = rsp_valid && !rsp_ready; while stalled all req_ready SHALL be 0 and rsp_valid/rsp_ch/rsp_data SHALL hold stable.
REQ-025 rsp_valid && rsp_ready with a new read grant in same cycle -> back-to-back responses, no bubble; without new read, rsp_valid deasserts next cycle.
REQ-026 Address out of range impossible (full decode); addresses wrap naturally at ADDR_WIDTH.
REQ-027 States: INIT (clear sweep, macro only), RUN; RUN is the only state granting requests.

Reset
REQ-028 reset_n low: rsp_valid=0, rsp_ch=0, rsp_data=0, rr_ptr=0, req_ready=0, state=INIT if macro defined else RUN; applies immediately, including mid-response.
REQ-029 Array contents SHALL NOT be reset except via the INIT sweep.

Configuration
REQ-030 Macro RF_BUF_CLEAR_ON_RESET_EN defined: after reset release FSM writes 0 to addresses 0..DEPTH-1, one per cycle (DEPTH cycles), init_done=0 and req_ready=0 throughout, then enters RUN with init_done=1.
REQ-031 Macro undefined: no INIT state, init_done=1 from the first cycle after reset release, array contents undefined until written.

Verification (NUM_CH=2, ADDR_WIDTH=4, DATA_WIDTH=32)
REQ-032 Ch0 write addr 3 = 0xDEADBEEF be 0xF; ch1 read addr 3 -> next cycle rsp_valid=1, rsp_ch=1, rsp_data=0xDEADBEEF.
REQ-033 Then ch0 write addr 3 = 0x11223344 be 0x5; read addr 3 -> rsp_data=0xDE22BE44.
REQ-034 Both channels req_valid held high, reads, rsp_ready=1 -> grants alternate ch0,ch1,ch0,ch1, one rsp_valid every cycle.
REQ-035 rsp_ready low 3 cycles with rsp_valid=1 -> req_ready=00 and rsp outputs unchanged for 3 cycles; release -> traffic resumes next cycle.
REQ-036 reset_n pulsed low while rsp_valid=1 -> rsp_valid=0 immediately; after release first grant goes to ch0 when both valid.
REQ-037 With RF_BUF_CLEAR_ON_RESET_EN: init_done=0 for 16 cycles after release, req_ready=00; then read of every address returns 0x00000000.

Source files
------------

// File: rtl/rf_array_buffer_arb_if.sv
// Request/response bus for rf_array_buffer_arb.
// master: requesting side (drives requests, accepts responses).
// slave : the arbitrated array buffer.
interface rf_array_buffer_arb_if #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BE_W = DATA_WIDTH / 8;

  logic [NUM_CH-1:0]            req_valid;
  logic [NUM_CH-1:0]            req_ready;
  logic [NUM_CH-1:0]            req_write;
  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_CH*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_CH*BE_W-1:0]       req_be;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [CH_W-1:0]              rsp_ch;
  logic [DATA_WIDTH-1:0]        rsp_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_ch, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_ch, rsp_data
  );
endinterface

// File: rtl/rf_array_buffer_arb.sv
// rf_array_buffer_arb: single-port DEPTH x DATA_WIDTH array shared by NUM_CH
// channels through a round-robin arbiter. Reads return one cycle after the
// grant; a stalled response blocks all new grants.
// Optional macro RF_BUF_CLEAR_ON_RESET_EN: after reset, sweep zeros through the
// whole array (DEPTH cycles) before accepting traffic.
module rf_array_buffer_arb #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rf_array_buffer_arb_if.slave  bus,
  output logic                  init_done
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BE_W  = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [CH_W-1:0]       rsp_ch_q, rsp_ch_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  init_done_q, init_done_d;

  logic                  grant_vld_s;
  logic [CH_W-1:0]       grant_idx_s;
  logic                  grant_s;
  logic                  stall_s;
  logic                  sel_write_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [BE_W-1:0]       sel_be_s;
  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic [BE_W-1:0]       mem_be_s;

`ifdef RF_BUF_CLEAR_ON_RESET_EN
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
`endif

  // Round-robin search: first valid channel at or above rr_ptr (mod NUM_CH).
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      if (!grant_vld_s && bus.req_valid[(int'(rr_ptr_q) + off) % NUM_CH]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = CH_W'((int'(rr_ptr_q) + off) % NUM_CH);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  assign stall_s = rsp_valid_q && !bus.rsp_ready;
  assign grant_s = grant_vld_s && init_done_q && !stall_s;

  // One-hot grant onto req_ready; silent while stalled, initialising or in reset.
  always_comb begin
    bus.req_ready = '0;
    if (grant_s) begin
      bus.req_ready[grant_idx_s] = 1'b1;
    end else begin
      bus.req_ready = '0;
    end
  end

  assign sel_write_s = bus.req_write[grant_idx_s];
  assign sel_addr_s  = bus.req_addr[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata_s = bus.req_wdata[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_be_s    = bus.req_be[int'(grant_idx_s)*BE_W +: BE_W];

  // Next-state for arbiter pointer, response register and init sequencing.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_ch_d    = rsp_ch_q;
    rsp_data_d  = rsp_data_q;
    mem_we_s    = grant_s && sel_write_s;
    mem_addr_s  = sel_addr_s;
    mem_wdata_s = sel_wdata_s;
    mem_be_s    = sel_be_s;

    if (grant_s) begin
      rr_ptr_d = (grant_idx_s == CH_W'(NUM_CH - 1)) ? '0 : grant_idx_s + CH_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end

    if (grant_s && !sel_write_s) begin
      rsp_valid_d = 1'b1;
      rsp_ch_d    = grant_idx_s;
      rsp_data_d  = mem[sel_addr_s];
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end

`ifdef RF_BUF_CLEAR_ON_RESET_EN
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      ST_INIT: begin
        mem_we_s    = 1'b1;
        mem_addr_s  = init_addr_q;
        mem_wdata_s = '0;
        mem_be_s    = '1;
        init_addr_d = init_addr_q + ADDR_WIDTH'(1);
        if (init_addr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
    init_done_d = (state_d == ST_RUN);
`else
    init_done_d = 1'b1;
`endif
  end

  // Control and response registers; array contents are deliberately excluded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= '0;
      rsp_data_q  <= '0;
      init_done_q <= 1'b0;
`ifdef RF_BUF_CLEAR_ON_RESET_EN
      state_q     <= ST_INIT;
      init_addr_q <= '0;
`endif
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ch_q    <= rsp_ch_d;
      rsp_data_q  <= rsp_data_d;
      init_done_q <= init_done_d;
`ifdef RF_BUF_CLEAR_ON_RESET_EN
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
`endif
    end
  end

  // Storage array write port with per-byte enables.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int k = 0; k < BE_W; k++) begin
        if (mem_be_s[k]) begin
          mem[mem_addr_s][k*8 +: 8] <= mem_wdata_s[k*8 +: 8];
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_ch    = rsp_ch_q;
  assign bus.rsp_data  = rsp_data_q;
  assign init_done     = init_done_q;
endmodule
